// File: rtl/seg_pkg.sv
// seg_pkg: shared segment bit positions, hex glyph table and digit bound for the scanner
package seg_pkg;
  localparam int DIGITS_MAX = 8;
  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;
  // Glyphs are {a,b,c,d,e,f,g}, active high; b and d use lowercase shapes
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'b1111110;
      4'h1: hex_to_seg = 7'b0110000;
      4'h2: hex_to_seg = 7'b1101101;
      4'h3: hex_to_seg = 7'b1111001;
      4'h4: hex_to_seg = 7'b0110011;
      4'h5: hex_to_seg = 7'b1011011;
      4'h6: hex_to_seg = 7'b1011111;
      4'h7: hex_to_seg = 7'b1110000;
      4'h8: hex_to_seg = 7'b1111111;
      4'h9: hex_to_seg = 7'b1111011;
      4'hA: hex_to_seg = 7'b1110111;
      4'hB: hex_to_seg = 7'b0011111;
      4'hC: hex_to_seg = 7'b1001110;
      4'hD: hex_to_seg = 7'b0111101;
      4'hE: hex_to_seg = 7'b1001111;
      default: hex_to_seg = 7'b1000111;
    endcase
  endfunction
endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational 4-bit nibble to abcdefg glyph
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] abcdefg
);
  assign abcdefg = hex_to_seg(nib);
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scanner with blanking gap; optional SEG_LEADING_ZERO_SUPPRESS_EN
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int SCAN_DIV   = 2000,
  parameter int GAP_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [4*DIGITS-1:0]   wr_data,
  input  logic [DIGITS-1:0]     wr_dp,
  input  logic [DIGITS-1:0]     blank,
  output logic [DIGITS-1:0]     ena,
  output logic [7:0]            seg
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS_MAX);
  logic [4*DIGITS-1:0] sh_data;
  logic [DIGITS-1:0]   sh_dp;
  logic [CW-1:0]       div_cnt;
  logic [IW-1:0]       digit_idx;
  logic [3:0]          nib;
  logic [6:0]          glyph;
  logic                sup;
  logic                in_gap;
  assign nib    = sh_data[{digit_idx, 2'b00} +: 4];
  assign in_gap = div_cnt < CW'(GAP_CYCLES);
  seg_hex_decode u_dec (.nib(nib), .abcdefg(glyph));
`ifdef SEG_LEADING_ZERO_SUPPRESS_EN
  logic [DIGITS-1:0] lz;
  // A digit is a leading zero when it and every higher digit are zero; digit 0 is never suppressed
  always_comb begin
    lz = '0;
    lz[DIGITS-1] = ~|sh_data[4*(DIGITS-1) +: 4];
    for (int i = DIGITS - 2; i >= 0; i--) lz[i] = lz[i+1] & ~|sh_data[4*i +: 4];
    lz[0] = 1'b0;
  end
  assign sup = lz[digit_idx];
`else
  assign sup = 1'b0;
`endif
  // Shadow register holding the displayed word and decimal points
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_data <= '0;
      sh_dp   <= '0;
    end else if (wr_en) begin
      sh_data <= wr_data;
      sh_dp   <= wr_dp;
    end
  end
  // Slot divider and digit index; the index wraps exactly at DIGITS-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      digit_idx <= '0;
    end else begin
      div_cnt <= (div_cnt == CW'(SCAN_DIV - 1)) ? '0 : div_cnt + 1'b1;
      if (div_cnt == CW'(SCAN_DIV - 1))
        digit_idx <= (digit_idx == IW'(DIGITS - 1)) ? '0 : digit_idx + 1'b1;
    end
  end
  // Registered pins: dark during the gap, one-hot enable otherwise, segments dark when blanked
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ena <= '0;
      seg <= '0;
    end else begin
      ena <= in_gap ? '0 : {{(DIGITS-1){1'b0}}, 1'b1} << digit_idx;
      seg <= (in_gap || blank[digit_idx]) ? 8'h00 : {sup ? 7'b0 : glyph, sh_dp[digit_idx]};
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl at 8 and 6 digits
module tb_seg_scan_ctrl;
  localparam int SD  = 8;
  localparam int GAP = 2;
  localparam logic [6:0] TBL [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  logic        clk = 0, rst = 1, wr_en = 0;
  logic [31:0] wr_data = '0;
  logic [7:0]  wr_dp = '0, blank = '0;
  logic [7:0]  ena, seg, seg6;
  logic [5:0]  ena6;
  int checks = 0, errors = 0;
  logic [15:0] q8[$], q6[$];
  logic [15:0] exp;
  int          n = 0;
  logic [31:0] m_data = '0;
  logic [7:0]  m_dp = '0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIGITS(8), .SCAN_DIV(SD), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_dp(wr_dp),
    .blank(blank), .ena(ena), .seg(seg));
  seg_scan_ctrl #(.DIGITS(6), .SCAN_DIV(SD), .GAP_CYCLES(GAP)) dut6 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data[23:0]), .wr_dp(wr_dp[5:0]),
    .blank(blank[5:0]), .ena(ena6), .seg(seg6));

  function automatic logic [15:0] expect_out(int p, int d, logic [31:0] data, logic [7:0] dp, logic [7:0] bl);
    int c, i;
    logic lz;
    logic [7:0] e, s;
    c = p % SD;
    i = (p / SD) % d;
    if (c < GAP) return 16'h0000;
    e = 8'd1 << i;
    lz = 1'b0;
`ifdef SEG_LEADING_ZERO_SUPPRESS_EN
    lz = (i > 0);
    for (int k = i; k < d; k++) if (data[4*k +: 4] != 4'h0) lz = 1'b0;
`endif
    s = bl[i] ? 8'h00 : {lz ? 7'b0 : TBL[data[4*i +: 4]], dp[i]};
    return {e, s};
  endfunction

  // Reference: output after the n-th edge since release reflects slot position n-1
  always @(posedge clk) begin
    if (rst) begin
      n = 0; m_data = '0; m_dp = '0;
      q8.push_back(16'h0000); q6.push_back(16'h0000);
    end else begin
      q8.push_back(expect_out(n, 8, m_data, m_dp, blank));
      q6.push_back(expect_out(n, 6, m_data, m_dp, blank));
      if (wr_en) begin m_data = wr_data; m_dp = wr_dp; end
      n++;
    end
  end

  task automatic flush();
    @(negedge clk);
    q8.delete(); q6.delete();
  endtask

  task automatic write(input logic [31:0] d, input logic [7:0] dp);
    wr_data = d; wr_dp = dp; wr_en = 1;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({ena, seg, ena6, seg6} !== 30'h0) begin
        errors++; $display("FAIL reset_state got ena=%h seg=%h ena6=%h seg6=%h want all 0", ena, seg, ena6, seg6);
      end
    end
    rst = 0;
  endtask

  task automatic test_scan();
    write(32'h1234ABCD, 8'h00);
    flush();
    repeat (2 * 8 * SD) begin
      @(negedge clk);
      exp = q8.size() != 0 ? q8.pop_front() : 16'hxxxx;
      checks++;
      if ({ena, seg} !== exp) begin
        errors++; $display("FAIL scan8 got ena=%h seg=%b want ena=%h seg=%b", ena, seg, exp[15:8], exp[7:0]);
      end
    end
    for (int k = 0; k < 100 && ena !== 8'h02; k++) @(negedge clk);
    checks++;
    if (ena !== 8'h02 || seg !== 8'b1001_1100) begin
      errors++; $display("FAIL scan_digit1_C got ena=%h seg=%b want 02 10011100", ena, seg);
    end
    for (int k = 0; k < 100 && ena !== 8'h01; k++) @(negedge clk);
    checks++;
    if (ena !== 8'h01 || seg !== 8'b0111_1010) begin
      errors++; $display("FAIL scan_digit0_d got ena=%h seg=%b want 01 01111010", ena, seg);
    end
  endtask

  task automatic test_digits6();
    flush();
    repeat (3 * 6 * SD) begin
      @(negedge clk);
      exp = q6.size() != 0 ? q6.pop_front() : 16'hxxxx;
      checks++;
      if ({2'b00, ena6, seg6} !== exp || $countones(ena6) > 1) begin
        errors++; $display("FAIL scan6 got ena=%h seg=%b want ena=%h seg=%b", ena6, seg6, exp[15:8], exp[7:0]);
      end
    end
  endtask

  task automatic test_dp_blank();
    write(32'h0, 8'h04);
    flush();
    for (int ph = 0; ph < 2; ph++) begin
      blank = ph == 1 ? 8'h01 : 8'h00;
      flush();
      repeat (8 * SD) begin
        @(negedge clk);
        exp = q8.size() != 0 ? q8.pop_front() : 16'hxxxx;
        checks++;
        if ({ena, seg} !== exp || (ena == 8'h04 && seg !== 8'b1111_1101) || (ph == 1 && ena == 8'h01 && seg !== 8'h00)) begin
          errors++; $display("FAIL dp_blank%0d got ena=%h seg=%b want ena=%h seg=%b", ph, ena, seg, exp[15:8], exp[7:0]);
        end
      end
    end
    blank = 8'h00;
  endtask

  task automatic test_reset_mid();
    write(32'h1234ABCD, 8'hFF);
    for (int k = 0; k < 200 && ena !== 8'h08; k++) @(negedge clk);
    @(negedge clk);
    rst = 1;
    #1;
    checks++;
    if (ena !== 8'h00 || seg !== 8'h00) begin
      errors++; $display("FAIL reset_mid_async got ena=%h seg=%h want 00 00", ena, seg);
    end
    repeat (2) @(negedge clk);
    rst = 0;
    q8.delete(); q6.delete();
    for (int k = 0; k < 3 * SD; k++) begin
      @(negedge clk);
      exp = q8.size() != 0 ? q8.pop_front() : 16'hxxxx;
      checks++;
      if ({ena, seg} !== exp || (k < 2 && {ena, seg} !== 16'h0) || (k == 2 && {ena, seg} !== 16'h01FC)) begin
        errors++; $display("FAIL reset_release[%0d] got ena=%h seg=%h want ena=%h seg=%h", k, ena, seg, exp[15:8], exp[7:0]);
      end
    end
  endtask

  task automatic test_write_mid();
    for (int k = 0; k < 200 && ena !== 8'h02; k++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (ena !== 8'h02 || seg !== 8'b1111_1100) begin
      errors++; $display("FAIL write_mid_before got ena=%h seg=%b want 02 11111100", ena, seg);
    end
    q8.delete();
    write(32'h000000F0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      exp = q8.size() != 0 ? q8.pop_front() : 16'hxxxx;
      checks++;
      if ({ena, seg} !== exp || ena !== 8'h02 || (k > 0 && seg !== 8'b1000_1110)) begin
        errors++; $display("FAIL write_mid[%0d] got ena=%h seg=%b want ena=%h seg=%b", k, ena, seg, exp[15:8], exp[7:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    wr_en = 1;
    flush();
    for (int k = 0; k < 4 * SD; k++) begin
      wr_data = 32'h11111111 * (k % 16); wr_dp = 8'(k);
      @(negedge clk);
      exp = q8.size() != 0 ? q8.pop_front() : 16'hxxxx;
      checks++;
      if ({ena, seg} !== exp || $countones(ena) > 1) begin
        errors++; $display("FAIL back_to_back[%0d] got ena=%h seg=%b want ena=%h seg=%b", k, ena, seg, exp[15:8], exp[7:0]);
      end
    end
    wr_en = 0;
  endtask

`ifdef SEG_LEADING_ZERO_SUPPRESS_EN
  task automatic test_lzs();
    write(32'h00000F00, 8'h00);
    flush();
    repeat (8 * SD) begin
      @(negedge clk);
      exp = q8.size() != 0 ? q8.pop_front() : 16'hxxxx;
      checks++;
      if ({ena, seg} !== exp || (ena == 8'h04 && seg !== 8'b1000_1110) || (ena >= 8'h08 && seg !== 8'h00)) begin
        errors++; $display("FAIL lzs got ena=%h seg=%b want ena=%h seg=%b", ena, seg, exp[15:8], exp[7:0]);
      end
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_scan();
    test_digits6();
    test_dp_blank();
    test_reset_mid();
    test_write_mid();
    test_back_to_back();
`ifdef SEG_LEADING_ZERO_SUPPRESS_EN
    test_lzs();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
